// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable multi-pattern serial sequence detector.
// Compares the most recent qualified bits against NUM_PAT runtime-loadable
// patterns (up to MAX_LEN bits each) and emits a registered one-cycle pulse
// per slot on a match. Overlapping/non-overlapping detection is selectable.
// Optional feature: define SEQDET_MATCH_CNT_EN to build the saturating
// match counter; otherwise match_cnt is tied to 0 and cnt_clr is ignored.
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int NUM_PAT = 2,
    parameter int CNT_W   = 8,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int IW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_idx,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cnt_clr,
    output logic [NUM_PAT-1:0] y,
    output logic               y_any,
    output logic [CNT_W-1:0]   match_cnt
);

    // Reset-time slot contents: slot 0 detects 110, slot 1 detects 101.
    localparam logic [15:0]   RST_PAT0 = 16'b110;
    localparam logic [15:0]   RST_PAT1 = 16'b101;
    localparam logic [LW-1:0] RST_LEN  = LW'((MAX_LEN < 3) ? MAX_LEN : 3);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    // The oldest history bit is shifted out before it can ever be compared,
    // so only MAX_LEN-1 bits are stored; hist_nxt is the full MAX_LEN window.
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;

    logic [MAX_LEN-1:0] pat   [NUM_PAT];
    logic [LW-1:0]      len   [NUM_PAT];
    logic [LW-1:0]      seen  [NUM_PAT];
    logic [MAX_LEN-1:0] masks [NUM_PAT];

    logic [NUM_PAT-1:0] wr_sel;
    logic [NUM_PAT-1:0] match;
    logic [LW-1:0]      len_clamped;

    assign hist_nxt = {hist, x};

    // Decode the slot write and clamp the requested pattern length.
    always_comb begin
        len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
        wr_sel      = '0;
        for (int unsigned i = 0; i < NUM_PAT; i++) begin
            wr_sel[i] = cfg_we && (cfg_idx == IW'(i));
        end
    end

    // Build a per-slot mask selecting the low len bits of the window.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PAT; i++) begin
            masks[i] = '0;
            for (int unsigned b = 0; b < MAX_LEN; b++) begin
                masks[i][b] = (LW'(b) < len[i]);
            end
        end
    end

    // Evaluate every slot against the window that includes the incoming bit.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < NUM_PAT; i++) begin
            match[i] = x_valid
                    && (len[i] != '0)
                    && (({1'b0, seen[i]} + 1'b1) >= {1'b0, len[i]})
                    && (((hist_nxt ^ pat[i]) & masks[i]) == '0)
                    && !wr_sel[i];
        end
    end

    // History shift, slot configuration, seen counters and match outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist  <= '0;
            y     <= '0;
            y_any <= 1'b0;
            for (int unsigned i = 0; i < NUM_PAT; i++) begin
                seen[i] <= '0;
                if (i == 0) begin
                    pat[i] <= RST_PAT0[MAX_LEN-1:0];
                    len[i] <= RST_LEN;
                end else if (i == 1) begin
                    pat[i] <= RST_PAT1[MAX_LEN-1:0];
                    len[i] <= RST_LEN;
                end else begin
                    pat[i] <= '0;
                    len[i] <= '0;
                end
            end
        end else begin
            if (x_valid) begin
                hist <= hist_nxt[MAX_LEN-2:0];
            end
            for (int unsigned i = 0; i < NUM_PAT; i++) begin
                if (wr_sel[i]) begin
                    pat[i]  <= cfg_pat;
                    len[i]  <= len_clamped;
                    seen[i] <= '0;
                end else if (x_valid) begin
                    if (match[i] && !overlap) begin
                        seen[i] <= '0;
                    end else if (seen[i] < len[i]) begin
                        seen[i] <= seen[i] + 1'b1;
                    end
                end
            end
            y     <= match;
            y_any <= |match;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    // Saturating count of edges with at least one slot match; clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if ((|match) && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign match_cnt = cnt;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed self-checking bench for seq_detect_prog.
// A second instance with CNT_W=2 shares all inputs to exercise saturation.
module tb_seq_detect_prog;

    logic       clk     = 1'b0;
    logic       rstn    = 1'b1;
    logic       x       = 1'b0;
    logic       x_valid = 1'b0;
    logic       overlap = 1'b1;
    logic       cfg_we  = 1'b0;
    logic       cfg_idx = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cnt_clr = 1'b0;

    logic [1:0] y, y2;
    logic       y_any, y_any2;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;
    int stepno = 0;

    logic       clr_req = 1'b0;
    logic [7:0] e1      = '0;
    logic [1:0] e2      = '0;

    seq_detect_prog #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .y(y), .y_any(y_any), .match_cnt(cnt1)
    );

    seq_detect_prog #(.MAX_LEN(8), .NUM_PAT(2), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .x(x), .x_valid(x_valid), .overlap(overlap),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cnt_clr(cnt_clr), .y(y2), .y_any(y_any2), .match_cnt(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] ey);
        chk({tag, "_y"},     32'(y),      32'(ey));
        chk({tag, "_yany"},  32'(y_any),  32'(|ey));
        chk({tag, "_y2"},    32'(y2),     32'(ey));
        chk({tag, "_yany2"}, 32'(y_any2), 32'(|ey));
        chk({tag, "_cnt"},   32'(cnt1),   32'(e1));
        chk({tag, "_cnt2"},  32'(cnt2),   32'(e2));
    endtask

    // One qualified bit; ey is the y vector expected after its edge.
    task automatic step(input logic b, input logic [1:0] ey);
        @(negedge clk);
        x       = b;
        x_valid = 1'b1;
        cnt_clr = clr_req;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        cnt_clr = 1'b0;
`ifdef SEQDET_MATCH_CNT_EN
        if (clr_req) begin
            e1 = '0;
            e2 = '0;
        end else if (ey != 2'b00) begin
            if (e1 != 8'hFF) e1 = e1 + 8'd1;
            if (e2 != 2'b11) e2 = e2 + 2'd1;
        end
`endif
        stepno++;
        check_outs($sformatf("step%0d", stepno), ey);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check_outs($sformatf("idle%0d_%0d", stepno, k), 2'b00);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        e1 = '0;
        e2 = '0;
    endtask

    task automatic cfg_write(input logic idx, input logic [7:0] p, input logic [3:0] l);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_pat = p;
        cfg_len = l;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        check_outs("cfgwr", 2'b00);
    endtask

    initial begin
        // Asynchronous reset from time zero.
        #1 rstn = 1'b0;
        #2 check_outs("reset", 2'b00);
        @(negedge clk);
        rstn = 1'b1;

        // Default slots, overlapping: 101 after bits 5,7; 110 after bits 9,13.
        overlap = 1'b1;
        step(0, 2'b00); step(0, 2'b00); step(1, 2'b00); step(0, 2'b00);
        step(1, 2'b10); step(0, 2'b00); step(1, 2'b10); step(1, 2'b00);
        step(0, 2'b01); step(0, 2'b00); step(1, 2'b00); step(1, 2'b00);
        step(0, 2'b01);
        idle(1);

        // Non-overlapping 10101: single match after bit 3.
        do_reset();
        overlap = 1'b0;
        step(1, 2'b00); step(0, 2'b00); step(1, 2'b10); step(0, 2'b00);
        step(1, 2'b00);

        // Overlapping 10101: matches after bits 3 and 5.
        do_reset();
        overlap = 1'b1;
        step(1, 2'b00); step(0, 2'b00); step(1, 2'b10); step(0, 2'b00);
        step(1, 2'b10);

        // 8-bit pattern in slot 0; length 15 must clamp to 8. Gaps of 2 idles.
        do_reset();
        cfg_write(1'b0, 8'b10110011, 4'd15);
        step(1, 2'b00); idle(2);
        step(0, 2'b00); idle(2);
        step(1, 2'b10); idle(2);
        step(1, 2'b00); idle(2);
        step(0, 2'b00); idle(2);
        step(0, 2'b00); idle(2);
        step(1, 2'b00); idle(2);
        step(1, 2'b01); idle(2);

        // Slot 1 rewritten on the edge completing 101: match suppressed,
        // seen restarts so three fresh bits are needed.
        do_reset();
        step(1, 2'b00); step(0, 2'b00);
        @(negedge clk);
        x = 1'b1; x_valid = 1'b1;
        cfg_we = 1'b1; cfg_idx = 1'b1; cfg_pat = 8'b101; cfg_len = 4'd3;
        @(posedge clk);
        #1;
        x_valid = 1'b0; cfg_we = 1'b0;
        check_outs("wr_same_edge", 2'b00);
        step(0, 2'b00); step(1, 2'b00); step(0, 2'b00); step(1, 2'b10);

        // Asynchronous reset while a pulse is high clears outputs at once.
        do_reset();
        step(1, 2'b00); step(0, 2'b00); step(1, 2'b10);
        #2 rstn = 1'b0;
        #1;
        e1 = '0; e2 = '0;
        check_outs("async_rst_a", 2'b00);
        @(negedge clk);
        rstn = 1'b1;

        // Reset after bits 1,1 discards them: lone 0 gives nothing, 1,1,0 does.
        step(1, 2'b00); step(1, 2'b00);
        #2 rstn = 1'b0;
        #1 check_outs("async_rst_b", 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        step(0, 2'b00);
        step(1, 2'b00); step(1, 2'b00); step(0, 2'b01);

        // Five overlapping 101 matches saturate the 2-bit counter at 3;
        // cnt_clr on a matching edge wins over the increment.
        do_reset();
        overlap = 1'b1;
        step(1, 2'b00); step(0, 2'b00); step(1, 2'b10); step(0, 2'b00);
        step(1, 2'b10); step(0, 2'b00); step(1, 2'b10); step(0, 2'b00);
        step(1, 2'b10); step(0, 2'b00); step(1, 2'b10);
        step(0, 2'b00);
        clr_req = 1'b1;
        step(1, 2'b10);
        clr_req = 1'b0;
        step(0, 2'b00); step(1, 2'b10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable multi-pattern serial sequence detector for the sequence-detector family. It replaces the fixed 110/101 detector with a generalised block. It watches a qualified serial bit stream and compares the most recent bits against NUM_PAT runtime-loadable patterns, each up to MAX_LEN bits long. Each pattern gets a registered one-cycle match pulse, and overlapping or non-overlapping detection is selectable. Intended as the drop-in detector for lab datapaths that need more than two hard-wired sequences.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16)
- NUM_PAT, 2: number of independent pattern slots (1..8)
- CNT_W, 8: match counter width
- LW: localparam, $clog2(MAX_LEN+1), length field width
- IW: localparam, max(1,$clog2(NUM_PAT)), slot index width

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- x  in  1  serial data bit
- x_valid  in  1  x sampled only when high
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_we  in  1  pattern slot write strobe
- cfg_idx  in  IW  slot to write; out-of-range index ignored
- cfg_pat  in  MAX_LEN  pattern, bit 0 = most recent (last-arriving) bit
- cfg_len  in  LW  pattern length; 0 disables the slot; values > MAX_LEN clamp to MAX_LEN
- cnt_clr  in  1  synchronous match-counter clear
- y  out  NUM_PAT  per-slot match pulse, registered
- y_any  out  1  OR of y, registered
- match_cnt  out  CNT_W  saturating match count

## Operation
- hist[MAX_LEN-1:0] shift register. On x_valid: hist <= {hist[MAX_LEN-2:0], x}. Holds otherwise.
- Per-slot seen_i counter, LW bits:
  - increments on x_valid
  - saturates at len_i
- Slot i matches on an x_valid edge when all of the following hold:
  - len_i != 0
  - (seen_i+1) >= len_i
  - the low len_i bits of the new hist equal pat_i[len_i-1:0]
- Overlap=1: seen_i is not cleared on a match, so suffixes can be reused (10101 gives two 101 matches).
- Overlap=0: a match clears seen_i to 0, so the next match needs len_i fresh bits.
- Slot write (cfg_we, valid cfg_idx):
  - loads pat and the clamped len into the slot
  - clears seen_idx and y[idx] on that edge
  - hist is unaffected
- Simultaneous cfg_we and x_valid:
  - hist still shifts
  - the written slot's match is suppressed on that edge
  - other slots evaluate normally
- Reset values:
  - hist=0, all seen=0, y=0, y_any=0, match_cnt=0
  - slot 0 = pattern 3'b110, len 3
  - slot 1 (if NUM_PAT>=2) = pattern 3'b101, len 3
  - slots >=2 have len 0
- Reset mid-stream discards partial history; detection restarts from zero bits.

## Timing
- Latency: y[i] rises in the cycle after the clock edge that samples the completing bit. It is high for exactly one cycle.
- y and y_any are 0 in every cycle following an edge with x_valid=0.
- Back-to-back x_valid on consecutive cycles is supported. Consecutive matches produce consecutive y pulses.
- A change to overlap takes effect at the next x_valid edge. Existing seen counters are not modified.
- All outputs are registers. There is no combinational path from inputs to outputs.

## Configuration
- SEQDET_MATCH_CNT_EN defined:
  - match_cnt increments by 1 on each edge where any slot matches (multiple slots on one edge count once)
  - it saturates at 2^CNT_W-1
  - cnt_clr clears it and wins over a simultaneous increment
- Not defined:
  - no counter register
  - match_cnt is tied to 0
  - cnt_clr is ignored

## Test plan
- Reset defaults, overlap=1, stream 0,0,1,0,1,0,1,1,0,0,1,1,0 (one bit per cycle):
  - y[1] pulses after bits 5 and 7
  - y[0] pulses after bits 9 and 13
  - match_cnt=4 (with macro)
- overlap=0, stream 1,0,1,0,1:
  - y[1] pulses after bit 3 only
  - with overlap=1, also after bit 5
- Write slot 0 = 8'b10110011 len 8, then stream 1,0,1,1,0,0,1,1 with x_valid gaps of 2 idle cycles:
  - single y[0] pulse one cycle after bit 8
  - y stays 0 during the gaps
- cfg_we to slot 1 on the same edge as the bit completing 101:
  - no y[1] pulse
  - y[0] unaffected
  - subsequent 101 detected after 3 fresh bits
- Assert rstn low asynchronously mid-pattern (after bits 1,1):
  - outputs 0 immediately
  - after release, bit 0 alone gives no match
  - 1,1,0 then matches
- CNT_W=2, five matches gives match_cnt=3 (saturated). cnt_clr coincident with a match gives match_cnt=0.
